// File: rtl/f32m_acc_seq.sv
// Sequential multi-operand add/subtract accumulator over GF(3^{2m}), 2-bit trit encoding.
// Optional macro F3_TRIT_CHECK_EN adds a sticky err output for illegal (11) trits.
module f32m_acc_seq #(
  parameter int unsigned M       = 97,
  parameter int unsigned MAX_OPS = 8,
  parameter int unsigned CW      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CW-1:0]     num_ops,
  input  logic [4*M-1:0]    in_data,
  input  logic              in_neg,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [4*M-1:0]    sum,
  output logic              busy,
  output logic              done
`ifdef F3_TRIT_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned W  = 4 * M;
  localparam int unsigned NT = 2 * M;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_sum;
  logic [CW-1:0]   r_remaining;
  logic            w_in_ready_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_fire;
  logic            w_start_ok;
  logic            w_num_ok;
  logic [W-1:0]    w_addend;
  logic [W-1:0]    w_sum_acc;

  // Mod-3 trit add; an illegal 11 operand trit is treated as 0.
  function automatic logic [1:0] trit_add(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] r;
    x = (a == 2'b11) ? 2'b00 : a;
    y = (b == 2'b11) ? 2'b00 : b;
    case ({x, y})
      4'b0000: r = 2'b00;
      4'b0001: r = 2'b01;
      4'b0010: r = 2'b10;
      4'b0100: r = 2'b01;
      4'b0101: r = 2'b10;
      4'b0110: r = 2'b00;
      4'b1000: r = 2'b10;
      4'b1001: r = 2'b00;
      4'b1010: r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign w_num_ok   = (num_ops != '0) && (num_ops <= CW'(MAX_OPS));
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_fire     = r_in_ready && in_valid;

  // Negation swaps hi/lo of every trit, then trit-wise add into the running sum.
  always_comb begin
    w_addend  = in_data;
    w_sum_acc = r_sum;
    for (int i = 0; i < int'(NT); i++) begin
      if (in_neg) begin
        w_addend[2*i+:2] = {in_data[2*i], in_data[2*i+1]};
      end
      w_sum_acc[2*i+:2] = trit_add(r_sum[2*i+:2], w_addend[2*i+:2]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_num_ok ? S_ACC : S_FIN;
        end
      end
      S_ACC: begin
        if (w_fire && (r_remaining == CW'(1))) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they can be registered with it.
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    case (w_state_nxt)
      S_ACC: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      S_FIN: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sum       <= '0;
      r_remaining <= '0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      if (w_start_ok) begin
        r_sum       <= '0;
        r_remaining <= w_num_ok ? num_ops : '0;
      end else if (w_fire) begin
        r_sum       <= w_sum_acc;
        r_remaining <= r_remaining - CW'(1);
      end
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;

`ifdef F3_TRIT_CHECK_EN
  logic r_err;
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < int'(NT); i++) begin
      w_bad = w_bad | (in_data[2*i+1] & in_data[2*i]);
    end
  end

  // Sticky until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_fire && w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_f32m_acc_seq.sv
// Scoreboard bench for f32m_acc_seq: expected sums are queued at start and checked on done.
module tb_f32m_acc_seq;

  localparam int unsigned M       = 97;
  localparam int unsigned MAX_OPS = 8;
  localparam int unsigned CW      = 4;
  localparam int unsigned W       = 4 * M;
  localparam int unsigned NT      = 2 * M;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_ops = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_neg = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  sum;
  logic          busy;
  logic          done;
`ifdef F3_TRIT_CHECK_EN
  logic          err;
`endif

  f32m_acc_seq #(.M(M), .MAX_OPS(MAX_OPS), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_ops(num_ops),
    .in_data(in_data), .in_neg(in_neg), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .busy(busy), .done(done)
`ifdef F3_TRIT_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_done = 0;
  int n_push = 0;
  logic [W-1:0] exp_sum[$];
  int           exp_lat[$];
  logic [W-1:0] t_ops[0:15];
  logic         t_neg[0:15];
  logic [W-1:0] mon_es;
  int           mon_el;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [1:0] t);
    if (t == 2'b01) return 1;
    if (t == 2'b10) return 2;
    return 0;
  endfunction

  // Reference: per-trit integer arithmetic mod 3.
  function automatic logic [W-1:0] f3add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic neg);
    logic [W-1:0] r;
    int x;
    int y;
    r = '0;
    for (int t = 0; t < int'(NT); t++) begin
      x = dec(a[2*t+:2]);
      y = dec(b[2*t+:2]);
      if (neg) y = (3 - y) % 3;
      case ((x + y) % 3)
        1:       r[2*t+:2] = 2'b01;
        2:       r[2*t+:2] = 2'b10;
        default: r[2*t+:2] = 2'b00;
      endcase
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = '0;
    for (int t = 0; t < int'(NT); t++) begin
      case ($urandom_range(0, 2))
        1:       r[2*t+:2] = 2'b01;
        2:       r[2*t+:2] = 2'b10;
        default: r[2*t+:2] = 2'b00;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && done) begin
      n_done++;
      if (exp_sum.size() != 0) begin
        mon_es = exp_sum.pop_front();
        mon_el = exp_lat.pop_front();
        chk("sum", sum, mon_es);
        if (mon_el >= 0) chk("latency", W'(cyc - start_cyc), W'(mon_el));
        chk("ready_in_fin", W'(in_ready), W'(0));
        chk("busy_in_fin", W'(busy), W'(1));
      end
    end
  end

  task automatic wait_fire();
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("ready_timeout", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input int i);
    in_valid = 1'b1;
    in_data  = t_ops[i];
    in_neg   = t_neg[i];
    wait_fire();
  endtask

  task automatic run_acc(input int n, input int stall, input int lat_exp);
    logic [W-1:0] m;
    int n_ops;
    int k;
    m = '0;
    n_ops = (n >= 1 && n <= int'(MAX_OPS)) ? n : 0;
    for (int i = 0; i < n_ops; i++) m = f3add(m, t_ops[i], t_neg[i]);
    exp_sum.push_back(m);
    exp_lat.push_back(lat_exp);
    n_push++;
    @(posedge clk); #1;
    start = 1'b1;
    num_ops = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < n_ops; i++) begin
      drive_op(i);
      if (i < n_ops - 1 && stall > 0) begin
        in_valid = 1'b0;
        in_data  = rand_op();
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_busy", W'(busy), W'(1));
          chk("stall_ready", W'(in_ready), W'(1));
          chk("stall_done", W'(done), W'(0));
          start   = (s == 0);
          num_ops = CW'(2);
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    k = 0;
    while (exp_sum.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (exp_sum.size() != 0) begin
      chk("done_timeout", W'(exp_sum.size()), W'(0));
      exp_sum.delete();
      exp_lat.delete();
    end
    @(posedge clk); #1;
    chk("idle_busy", W'(busy), W'(0));
    chk("idle_ready", W'(in_ready), W'(0));
    chk("sum_hold", sum, m);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sum", sum, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_ready", W'(in_ready), W'(0));
    chk("rst_done", W'(done), W'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // 1+1+1 = 0 on every trit
    x = {NT{2'b01}};
    for (int i = 0; i < 3; i++) begin t_ops[i] = x; t_neg[i] = 1'b0; end
    run_acc(3, 0, 3);

    // X - X = 0, then X alone
    x = rand_op();
    t_ops[0] = x; t_neg[0] = 1'b0;
    t_ops[1] = x; t_neg[1] = 1'b1;
    run_acc(2, 0, 2);
    t_ops[0] = x; t_neg[0] = 1'b0;
    run_acc(1, 0, 1);
    chk("single_x", sum, x);

    // Stalled stream with random signs, start pulsed mid-stream
    for (int i = 0; i < 4; i++) begin t_ops[i] = rand_op(); t_neg[i] = 1'($urandom_range(0, 1)); end
    run_acc(4, 3, -1);

    // Degenerate counts, with in_valid held high to show nothing is consumed
    in_valid = 1'b1;
    in_data  = rand_op();
    run_acc(0, 0, 0);
    in_valid = 1'b1;
    run_acc(MAX_OPS + 1, 0, 0);
    for (int i = 0; i < int'(MAX_OPS); i++) begin t_ops[i] = rand_op(); t_neg[i] = 1'($urandom_range(0, 1)); end
    run_acc(int'(MAX_OPS), 0, int'(MAX_OPS));

    // Async reset mid-accumulation
    for (int i = 0; i < 5; i++) begin t_ops[i] = rand_op(); t_neg[i] = 1'b0; end
    @(posedge clk); #1;
    start = 1'b1;
    num_ops = CW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    drive_op(0);
    drive_op(1);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sum", sum, '0);
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_ready", W'(in_ready), W'(0));
    chk("arst_done", W'(done), W'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    x = rand_op();
    t_ops[0] = x; t_neg[0] = 1'b0;
    run_acc(1, 0, 1);
    chk("post_rst_y", sum, x);

`ifdef F3_TRIT_CHECK_EN
    x = rand_op();
    x[1:0] = 2'b11;
    t_ops[0] = x; t_neg[0] = 1'b0;
    t_ops[1] = rand_op(); t_neg[1] = 1'b1;
    run_acc(2, 0, 2);
    chk("err_sticky", W'(err), W'(1));
    t_ops[0] = rand_op(); t_neg[0] = 1'b0;
    run_acc(1, 0, 1);
    chk("err_clear", W'(err), W'(0));
`endif

    chk("done_count", W'(n_done), W'(n_push));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/f32m_acc_seq.md
Name: f32m_acc_seq

Overview:
- Sequential multi-operand accumulator over GF(3^{2m}); parametrised successor of the fixed three-operand combinational adder.
- Streams up to MAX_OPS operands through a valid/ready handshake.
- Per-operand add or subtract.
- Holds the running sum in a register and presents the result with a done pulse.
- Sits between pairing datapath units (Miller loop / final exponentiation) where variable-length sums of F_{3^{2m}} elements are needed.

Parameters:
M, 97, extension degree; one GF(3^m) element = 2*M bits, one GF(3^{2m}) element = 4*M bits
MAX_OPS, 8, maximum operands per accumulation (>=2)
CW, 4, width of operand count; must satisfy 2^CW > MAX_OPS

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a new accumulation (ignored unless idle)
num_ops  in  CW  operand count, sampled at start; legal 1..MAX_OPS
in_data  in  4*M  operand; low 2*M bits = coefficient 0, high 2*M bits = coefficient 1
in_neg  in  1  1 = subtract this operand, 0 = add
in_valid  in  1  operand valid
in_ready  out  1  block accepts operand this cycle
sum  out  4*M  accumulated result
busy  out  1  accumulation in progress
done  out  1  one-cycle pulse; sum is final

Behaviour:
- Trit encoding is 2 bits {hi,lo}: 00=0, 01=1, 10=2; 11 is illegal.
- Add is per trit mod 3. Negation swaps hi/lo (1<->2, 0 unchanged).
- Subtract = add of the negated operand. No carries between trits.
- States: IDLE, ACC, FIN.
- Reset (asynchronous, any state, mid-operation included):
  - state=IDLE, sum=0, count=0, busy=0, in_ready=0, done=0.
  - Any partial accumulation is discarded.
- IDLE:
  - in_ready=0.
  - start=1 with num_ops in 1..MAX_OPS: sum<=0, remaining<=num_ops, go ACC.
  - start with num_ops=0 or >MAX_OPS: go FIN directly with sum=0 (done pulses, no operand consumed).
- ACC:
  - busy=1, in_ready=1.
  - Handshake fires when in_valid & in_ready.
  - On fire: sum <= sum + (in_neg ? -in_data : in_data); remaining decrements.
  - Fire with remaining==1 goes FIN.
  - in_valid low inserts stall cycles; sum holds.
  - start in ACC is ignored.
- FIN:
  - One cycle; done=1, busy=1, in_ready=0; go IDLE.
  - sum is stable from FIN onward and holds until the next start is accepted.
- Latency: done asserts the cycle after the last operand is accepted. Minimum total is num_ops+1 cycles after start, with no stalls.
- Throughput: one operand per cycle.
- start coinciding with done (FIN cycle) is ignored; the caller must re-issue it in IDLE.
- in_data is not inspected when in_valid=0.
- sum updates register-only; no combinational path from in_data to sum.

Optional Feature:
- Macro F3_TRIT_CHECK_EN.
- When defined:
  - Adds output err (1 bit); reset value 0.
  - err is sticky: set when an accepted operand contains any trit == 11.
  - Cleared by reset or by the next accepted start.
  - The offending operand is still accumulated, treating 11 as 0.
- When not defined:
  - No err port.
  - 11 trits produce unspecified (but deterministic) result trits.

Test Plan:
1. M=97, start num_ops=3: operand A (all trits 1) add, operand B (all 1) add, operand C (all 1) add -> done one cycle after third accept, sum = all trits 0 (1+1+1=0 mod 3).
2. num_ops=2: X add, X subtract (X random legal) -> sum = 0; then num_ops=1, X add -> sum = X.
3. num_ops=4 with in_valid deasserted 3 cycles between operands -> sum equals software model, busy high throughout, done exactly once, in_ready high during stalls.
4. num_ops=0 -> done one cycle after start, sum=0, no handshake fires; num_ops=MAX_OPS streamed back-to-back -> done at cycle MAX_OPS+1.
5. Reset asserted after 2 of 5 operands accepted -> immediately sum=0, busy=0, in_ready=0; new start num_ops=1 with operand Y -> sum=Y.
6. (F3_TRIT_CHECK_EN) operand with trit0=11 accepted -> err=1 on the next cycle and stays set through done; next start -> err=0.
